// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one SPR_W x SPR_H sprite from a combinational ROM port into the framebuffer write port, clipping at screen edges.
// Optional build macro SPRITE_BLITTER_TRANSP_EN suppresses in-bounds pixels whose colour equals TRANSP.
module sprite_blitter #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 180,
  parameter int SPR_W  = 16,
  parameter int SPR_H  = 16,
  parameter int COLRW  = 4,
  parameter int TRANSP = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(FB_W)-1:0]         x,
  input  logic [$clog2(FB_H)-1:0]         y,
  output logic [$clog2(SPR_W*SPR_H)-1:0]  spr_addr,
  input  logic [COLRW-1:0]                spr_data,
  output logic                            fb_we,
  output logic [$clog2(FB_W*FB_H)-1:0]    fb_addr,
  output logic [COLRW-1:0]                fb_data,
  output logic                            busy,
  output logic                            done
);

  localparam int XW  = $clog2(FB_W);
  localparam int YW  = $clog2(FB_H);
  localparam int SAW = $clog2(SPR_W*SPR_H);
  localparam int FAW = $clog2(FB_W*FB_H);
  localparam int CW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int SXW = ((XW > CW) ? XW : CW) + 1;
  localparam int SYW = ((YW > RW) ? YW : RW) + 1;

`ifdef SPRITE_BLITTER_TRANSP_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [XW-1:0]  x_l;
  logic [YW-1:0]  y_l;
  logic [SXW-1:0] sx;
  logic [SYW-1:0] sy;
  logic           load, adv, last_px, col_wrap, inb, wr_cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    adv      = 1'b0;
    col_wrap = (col == CW'(SPR_W-1));
    last_px  = col_wrap && (row == RW'(SPR_H-1));
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = DRAW;
        end
      end
      DRAW: begin
        adv = 1'b1;
        if (last_px) state_d = FLUSH;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Screen coordinates carry one spare bit so the clip compare cannot wrap.
  always_comb begin
    sx      = SXW'(x_l) + SXW'(col);
    sy      = SYW'(y_l) + SYW'(row);
    inb     = (sx < SXW'(FB_W)) && (sy < SYW'(FB_H));
    wr_cand = inb && !(TRANSP_EN && (spr_data == COLRW'(TRANSP)));
  end

  // Counters freeze on the last pixel so spr_addr holds its final value in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_l <= '0;
      y_l <= '0;
      col <= '0;
      row <= '0;
    end else if (load) begin
      x_l <= x;
      y_l <= y;
      col <= '0;
      row <= '0;
    end else if (adv && !last_px) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      done    <= 1'b0;
    end else begin
      fb_we <= adv && wr_cand;
      if (adv && wr_cand) begin
        fb_addr <= FAW'(sy) * FAW'(FB_W) + FAW'(sx);
        fb_data <= spr_data;
      end
      done <= (state_q == FLUSH);
    end
  end

  assign spr_addr = SAW'(row) * SAW'(SPR_W) + SAW'(col);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed and random blits checked cycle by cycle against a pixel-list model.
// Honours SPRITE_BLITTER_TRANSP_EN the same way as the design build.
module tb_sprite_blitter;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  x = '0;
  logic [7:0]  y = '0;
  logic [7:0]  spr_addr;
  logic [3:0]  spr_data;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [3:0]  fb_data;
  logic        busy;
  logic        done;

  logic [3:0]  rom [0:N-1];
  bit          exp_we   [0:N-1];
  int          exp_addr [0:N-1];
  logic [3:0]  exp_data [0:N-1];

  int n_cmp = 0;
  int n_mis = 0;
  int nwr, first_a;

  always #5 clk = ~clk;

  assign spr_data = rom[spr_addr];

  sprite_blitter #(
    .FB_W(320), .FB_H(180), .SPR_W(16), .SPR_H(16), .COLRW(4), .TRANSP(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .spr_addr(spr_addr), .spr_data(spr_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_opaque(input logic [3:0] v);
    for (int k = 0; k < N; k++) rom[k] = v;
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) rom[k] = 4'($urandom_range(0, 15));
  endtask

  // Which sprite pixels should land on screen, and where.
  task automatic build_model(input int bx, input int by);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int k, sx, sy;
        bit vis;
        k  = r * 16 + c;
        sx = bx + c;
        sy = by + r;
        vis = (sx < 320) && (sy < 180);
`ifdef SPRITE_BLITTER_TRANSP_EN
        if (rom[k] == 4'h0) vis = 1'b0;
`endif
        exp_we[k]   = vis;
        exp_addr[k] = sy * 320 + sx;
        exp_data[k] = rom[k];
      end
  endtask

  // Entry: DUT in IDLE. Returns #1 after the done edge (or after reset release on abort).
  task automatic blit(input int bx, input int by, input int poke_at, input int abort_at,
                      input bit hold, output int wr_cnt, output int first_addr);
    build_model(bx, by);
    wr_cnt = 0;
    first_addr = -1;
    x = 9'(bx);
    y = 8'(by);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("we_after_start", 32'(fb_we), 32'd0);
    chk("done_after_start", 32'(done), 32'd0);
    chk("spr_addr_first", 32'(spr_addr), 32'd0);
    for (int i = 1; i <= N + 1; i++) begin
      if (i == poke_at) begin
        start = 1'b1;
        x = 9'($urandom_range(0, 319));
        y = 8'($urandom_range(0, 179));
      end else if (i == poke_at + 1 && !hold) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(fb_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_spr_addr", 32'(spr_addr), 32'd0);
        chk("abort_fb_addr", 32'(fb_addr), 32'd0);
        repeat (3) begin
          @(posedge clk); #1;
          chk("abort_hold_we", 32'(fb_we), 32'd0);
          chk("abort_hold_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (i <= N) begin
        chk("fb_we", 32'(fb_we), 32'(exp_we[i-1]));
        if (exp_we[i-1]) begin
          chk("fb_addr", 32'(fb_addr), 32'(exp_addr[i-1]));
          chk("fb_data", 32'(fb_data), 32'(exp_data[i-1]));
        end
        if (fb_we === 1'b1) begin
          if (wr_cnt == 0) first_addr = int'(fb_addr);
          wr_cnt++;
        end
        chk("busy_draw", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        if (i < N) chk("spr_addr", 32'(spr_addr), 32'(i));
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("we_at_done", 32'(fb_we), 32'd0);
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    @(posedge clk); #1;
    chk(tag, 32'({done, busy, fb_we}), 32'd0);
  endtask

  initial begin
    fill_opaque(4'h5);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_addr", 32'(fb_addr), 32'd0);
    chk("rst_data", 32'(fb_data), 32'd0);
    chk("rst_spr_addr", 32'(spr_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Opaque sprite at the origin.
    blit(0, 0, -1, -1, 1'b0, nwr, first_a);
    chk("opaque_count", 32'(nwr), 32'd256);
    chk("opaque_first", 32'(first_a), 32'd0);
    chk("spr_addr_hold", 32'(spr_addr), 32'd255);
    check_quiet("single_done_opaque");

    // Bottom-right clip.
    blit(312, 170, -1, -1, 1'b0, nwr, first_a);
    chk("clip_count", 32'(nwr), 32'd80);
    chk("clip_first", 32'(first_a), 32'd54712);
    check_quiet("single_done_clip");

    // Fully off-screen.
    blit(400, 200, -1, -1, 1'b0, nwr, first_a);
    chk("offscreen_count", 32'(nwr), 32'd0);

    // Checkerboard of transparent and 4'hA.
    for (int k = 0; k < N; k++) rom[k] = (((k / 16) + (k % 16)) % 2 == 1) ? 4'hA : 4'h0;
    blit(100, 50, -1, -1, 1'b0, nwr, first_a);
`ifdef SPRITE_BLITTER_TRANSP_EN
    chk("checker_count", 32'(nwr), 32'd128);
`else
    chk("checker_count", 32'(nwr), 32'd256);
`endif

    // Second start during DRAW must be ignored.
    fill_random();
    blit(37, 91, 50, -1, 1'b0, nwr, first_a);
    chk("poke_count", 32'(nwr), 32'd256);
    check_quiet("poke_single_done");
    check_quiet("poke_no_restart");

    // Reset in the middle of a blit, then a clean blit.
    fill_opaque(4'h7);
    blit(10, 10, -1, 100, 1'b0, nwr, first_a);
    chk("abort_partial_count", 32'(nwr), 32'd99);
    blit(20, 30, -1, -1, 1'b0, nwr, first_a);
    chk("post_abort_count", 32'(nwr), 32'd256);
    chk("post_abort_first", 32'(first_a), 32'(30 * 320 + 20));

    // Start held high: each done cycle accepts the next blit.
    fill_random();
    blit(5, 7, -1, -1, 1'b1, nwr, first_a);
    blit(0, 0, -1, -1, 1'b1, nwr, first_a);
    blit(310, 175, -1, -1, 1'b0, nwr, first_a);
    chk("b2b_last_count", 32'(nwr), 32'd50);
    check_quiet("b2b_end");

    // Random positions and sprite contents.
    for (int t = 0; t < 6; t++) begin
      int bx, by;
      fill_random();
      bx = (t % 2 == 0) ? int'($urandom_range(0, 319)) : int'($urandom_range(300, 340));
      by = (t % 2 == 0) ? int'($urandom_range(0, 179)) : int'($urandom_range(160, 200));
      blit(bx, by, -1, -1, 1'b0, nwr, first_a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
